// File: rtl/instr_assembler.sv
// Streaming instruction assembler: gathers opcode, ext and immediate bytes into one instruction with its PC.
// Latency: out_valid rises the cycle after the final byte transfer; one idle cycle between instructions.
// Backpressure: in_ready drops while an instruction is held; flush/reset override both handshakes.
module instr_assembler #(
   parameter int unsigned     IMM_BYTES    = 2,
   parameter int unsigned     PC_W         = 16,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter logic [15:0]     EXT_IMM_MASK = 16'h7C8C
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_byte,
   input  logic                   flush,
   input  logic [PC_W-1:0]        flush_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_opcode,
   output logic [1:0]             out_type,
   output logic [7:0]             out_ext,
   output logic [8*IMM_BYTES-1:0] out_imm,
   output logic [PC_W-1:0]        out_pc
);

   localparam int unsigned IMM_W = 8 * IMM_BYTES;
   localparam int unsigned CNT_W = (IMM_BYTES > 1) ? $clog2(IMM_BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IMM_BYTES - 1);

   localparam logic [1:0] TY_NORMAL     = 2'd0;
   localparam logic [1:0] TY_NORMAL_IMM = 2'd1;
   localparam logic [1:0] TY_EXT        = 2'd2;
   localparam logic [1:0] TY_EXT_IMM    = 2'd3;

   typedef enum logic [1:0] {
      S_OPC  = 2'd0,
      S_EXT  = 2'd1,
      S_IMM  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       opcode_q, opcode_d;
   logic [1:0]       type_q, type_d;
   logic [7:0]       ext_q, ext_d;
   logic [IMM_W-1:0] imm_q, imm_d;
   logic [PC_W-1:0]  opc_pc_q, opc_pc_d;
   logic             xfer;
   logic [1:0]       new_type;

   // Low nibble selects the family; extended opcodes consult the programmable map on bits [5:2].
   function automatic logic [1:0] classify(input logic [7:0] op);
      logic [1:0] ty;
      if (op[3:0] <= 4'd8) begin
         ty = TY_NORMAL;
      end else if (op[3:0] <= 4'd11) begin
         ty = TY_NORMAL_IMM;
      end else if (EXT_IMM_MASK[op[5:2]]) begin
         ty = TY_EXT_IMM;
      end else begin
         ty = TY_EXT;
      end
      return ty;
   endfunction

   assign new_type = classify(in_byte);
   assign xfer     = in_valid && in_ready;

   // Next-state, datapath capture and handshake outputs; flush overrides everything but reset.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      opcode_d  = opcode_q;
      type_d    = type_q;
      ext_d     = ext_q;
      imm_d     = imm_q;
      opc_pc_d  = opc_pc_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         S_OPC, S_EXT, S_IMM: in_ready  = 1'b1;
         S_HOLD:              out_valid = 1'b1;
         default:             in_ready  = 1'b0;
      endcase
      if (flush || !rst_n) begin
         in_ready = 1'b0;
      end

      if (flush) begin
         state_d = S_OPC;
         cnt_d   = '0;
         pc_d    = flush_pc;
      end else begin
         case (state_q)
            S_OPC: begin
               if (xfer) begin
                  opcode_d = in_byte;
                  type_d   = new_type;
                  opc_pc_d = pc_q;
                  // Clear optional fields so types without them read zero.
                  ext_d    = '0;
                  imm_d    = '0;
                  pc_d     = pc_q + PC_W'(1);
                  case (new_type)
                     TY_NORMAL:     state_d = S_HOLD;
                     TY_NORMAL_IMM: begin
                        state_d = S_IMM;
                        cnt_d   = CNT_LOAD;
                     end
                     default:       state_d = S_EXT;
                  endcase
               end
            end
            S_EXT: begin
               if (xfer) begin
                  ext_d = in_byte;
                  pc_d  = pc_q + PC_W'(1);
                  if (type_q == TY_EXT_IMM) begin
                     state_d = S_IMM;
                     cnt_d   = CNT_LOAD;
                  end else begin
                     state_d = S_HOLD;
                  end
               end
            end
            S_IMM: begin
               if (xfer) begin
                  // Bytes enter at the top and shift down, so the first byte ends up in bits [7:0].
                  imm_d = (imm_q >> 8) | (IMM_W'(in_byte) << (IMM_W - 8));
                  pc_d  = pc_q + PC_W'(1);
                  if (cnt_q == '0) begin
                     state_d = S_HOLD;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  state_d = S_OPC;
               end
            end
            default: state_d = S_OPC;
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_OPC;
         pc_q     <= RESET_PC;
         cnt_q    <= '0;
         opcode_q <= '0;
         type_q   <= '0;
         ext_q    <= '0;
         imm_q    <= '0;
         opc_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         opcode_q <= opcode_d;
         type_q   <= type_d;
         ext_q    <= ext_d;
         imm_q    <= imm_d;
         opc_pc_q <= opc_pc_d;
      end
   end

   assign out_opcode = opcode_q;
   assign out_type   = type_q;
   assign out_ext    = ext_q;
   assign out_imm    = imm_q;
   assign out_pc     = opc_pc_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: directed scenarios with literal expectations, then randomized traffic.
// A queue-based instruction model predicts handshakes and fields every cycle.
// A second instance with a 4-bit PC shares all inputs to exercise narrow-PC wrap.
module tb_instr_assembler;
   localparam int IMM = 2;
   localparam int IW  = 8 * IMM;
   localparam logic [15:0] MASK = 16'h7C8C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, in_valid, flush, out_ready;
   logic [7:0]    in_byte;
   logic [15:0]   flush_pc;
   logic          in_ready, out_valid;
   logic [7:0]    out_opcode, out_ext;
   logic [1:0]    out_type;
   logic [IW-1:0] out_imm;
   logic [15:0]   out_pc;
   logic          s_in_ready, s_out_valid;
   logic [7:0]    s_out_opcode, s_out_ext;
   logic [1:0]    s_out_type;
   logic [IW-1:0] s_out_imm;
   logic [3:0]    s_out_pc;

   instr_assembler #(.IMM_BYTES(IMM), .PC_W(16), .RESET_PC(16'h0000), .EXT_IMM_MASK(MASK)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
      .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_type(out_type), .out_ext(out_ext), .out_imm(out_imm), .out_pc(out_pc));

   instr_assembler #(.IMM_BYTES(IMM), .PC_W(4), .RESET_PC(4'h0), .EXT_IMM_MASK(MASK)) dut_small (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_byte(in_byte),
      .flush(flush), .flush_pc(flush_pc[3:0]), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_opcode(s_out_opcode), .out_type(s_out_type), .out_ext(s_out_ext), .out_imm(s_out_imm),
      .out_pc(s_out_pc));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]    m_bytes[$];
   logic [15:0]   m_pc = 16'h0000;
   logic [15:0]   m_opc_pc = 16'h0000;
   bit            m_hold = 1'b0;
   logic [7:0]    h_op = 8'h00, h_ext = 8'h00;
   logic [1:0]    h_type = 2'd0;
   logic [IW-1:0] h_imm = '0;
   logic [15:0]   h_pc = 16'h0000;

   function automatic int itype(input logic [7:0] op);
      if (op[3:0] <= 4'd8) return 0;
      if (op[3:0] <= 4'd11) return 1;
      return MASK[op[5:2]] ? 3 : 2;
   endfunction

   function automatic int ilen(input int t);
      case (t)
         0:       return 1;
         1:       return 1 + IMM;
         2:       return 2;
         default: return 2 + IMM;
      endcase
   endfunction

   // Compare on the falling edge, then advance the model with the inputs the next rising edge will see.
   always @(negedge clk) begin
      int t;
      int base;
      check("in_ready", in_ready, rst_n && !flush && !m_hold);
      check("out_valid", out_valid, m_hold);
      check("s_in_ready", s_in_ready, rst_n && !flush && !m_hold);
      check("s_out_valid", s_out_valid, m_hold);
      if (m_hold) begin
         check("opcode", out_opcode, h_op);
         check("type", out_type, h_type);
         check("ext", out_ext, h_ext);
         check("imm", out_imm, h_imm);
         check("pc", out_pc, h_pc);
         check("s_opcode", s_out_opcode, h_op);
         check("s_type", s_out_type, h_type);
         check("s_ext", s_out_ext, h_ext);
         check("s_imm", s_out_imm, h_imm);
         check("s_pc", s_out_pc, h_pc[3:0]);
      end
      if (!rst_n) begin
         m_pc = 16'h0000;
         m_bytes.delete();
         m_hold = 1'b0;
      end else if (flush) begin
         m_pc = flush_pc;
         m_bytes.delete();
         m_hold = 1'b0;
      end else if (m_hold) begin
         if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
         if (m_bytes.size() == 0) m_opc_pc = m_pc;
         m_bytes.push_back(in_byte);
         m_pc = m_pc + 16'd1;
         t = itype(m_bytes[0]);
         if (m_bytes.size() == ilen(t)) begin
            h_op   = m_bytes[0];
            h_type = 2'(t);
            h_pc   = m_opc_pc;
            h_ext  = (t >= 2) ? m_bytes[1] : 8'h00;
            h_imm  = '0;
            if (t == 1 || t == 3) begin
               base = (t == 1) ? 1 : 2;
               for (int k = 0; k < IMM; k++) h_imm = h_imm | (IW'(m_bytes[base + k]) << (8 * k));
            end
            m_hold = 1'b1;
            m_bytes.delete();
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_byte  = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for byte %0h, required 1", b);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL valid_timeout: out_valid stayed 0, required 1");
      end
   endtask

   task automatic accept();
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic expect_instr(input string tag, input logic [7:0] op, input logic [1:0] ty,
                               input logic [7:0] ext, input logic [IW-1:0] imm, input logic [15:0] pc);
      wait_valid();
      check({tag, "_opcode"}, out_opcode, op);
      check({tag, "_type"}, out_type, ty);
      check({tag, "_ext"}, out_ext, ext);
      check({tag, "_imm"}, out_imm, imm);
      check({tag, "_pc"}, out_pc, pc);
      accept();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0; flush_pc = 16'h0000; out_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_pc", out_pc, 16'h0000);
      tick();
      rst_n = 1'b1;
      tick();

      // Normal opcode: valid right after the transfer edge, input stalled while held.
      send(8'h05);
      @(negedge clk);
      check("lat_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      expect_instr("t1", 8'h05, 2'd0, 8'h00, 16'h0000, 16'h0000);

      send(8'h0A); send(8'h34); send(8'h12);
      expect_instr("t2", 8'h0A, 2'd1, 8'h00, 16'h1234, 16'h0001);
      send(8'h3C); send(8'h77);
      expect_instr("t3", 8'h3C, 2'd2, 8'h77, 16'h0000, 16'h0004);
      send(8'h1C); send(8'h55); send(8'hEF); send(8'hBE);
      expect_instr("t4", 8'h1C, 2'd3, 8'h55, 16'hBEEF, 16'h0006);

      // Stall with out_ready low and noisy input.
      send(8'h05);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         tick();
         in_valid = 1'($urandom_range(0, 1));
         in_byte  = 8'($urandom);
         @(negedge clk);
         check("stall_opcode", out_opcode, 8'h05);
         check("stall_pc", out_pc, 16'h000A);
      end
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      check("release_valid", out_valid, 1'b0);
      tick();
      send(8'h01);
      expect_instr("t5", 8'h01, 2'd0, 8'h00, 16'h0000, 16'h000B);

      // Flush mid-immediate drops the partial instruction.
      send(8'h0A); send(8'h34);
      flush = 1'b1; flush_pc = 16'h0100; in_valid = 1'b1; in_byte = 8'h99;
      @(negedge clk);
      check("flush_in_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      send(8'h01);
      expect_instr("t6", 8'h01, 2'd0, 8'h00, 16'h0000, 16'h0100);

      // Reset while collecting immediates.
      send(8'h0A); send(8'h34);
      rst_n = 1'b0; in_valid = 1'b1; in_byte = 8'h12;
      @(negedge clk);
      check("rst2_in_ready", in_ready, 1'b0);
      tick();
      @(negedge clk);
      check("rst2_valid", out_valid, 1'b0);
      check("rst2_opcode", out_opcode, 8'h00);
      check("rst2_type", out_type, 2'd0);
      check("rst2_ext", out_ext, 8'h00);
      check("rst2_imm", out_imm, 16'h0000);
      check("rst2_pc", out_pc, 16'h0000);
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      send(8'h05);
      expect_instr("t7", 8'h05, 2'd0, 8'h00, 16'h0000, 16'h0000);

      // PC wrap mid-instruction on both PC widths.
      flush = 1'b1; flush_pc = 16'hFFFF;
      tick();
      flush = 1'b0;
      send(8'h09); send(8'hAA); send(8'hBB);
      wait_valid();
      check("wrap_type", out_type, 2'd1);
      check("wrap_imm", out_imm, 16'hBBAA);
      check("wrap_pc", out_pc, 16'hFFFF);
      check("wrap_s_pc", s_out_pc, 4'hF);
      accept();
      send(8'h05);
      wait_valid();
      check("wrap_next_pc", out_pc, 16'h0002);
      check("wrap_next_s_pc", s_out_pc, 4'h2);
      accept();

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         flush     = ($urandom_range(0, 59) == 0);
         flush_pc  = 16'($urandom);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_byte   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
